// File: rtl/fetch_line_feeder.sv
// Fetch-queue producer: reads aligned instruction lines from memory and pushes
// them into the fetch queue, flushing and restarting on redirects.
`timescale 1ns/1ps

module fetch_line_feeder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_redirect,
    input  logic [ADDR_WIDTH-1:0]             i_redirect_pc,
    output logic                              o_mem_req,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    input  logic                              i_mem_ack,
    input  logic                              i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             i_mem_rdata,
    output logic                              o_q_wen,
    output logic [DATA_WIDTH-1:0]             o_q_wdata,
    output logic [ADDR_WIDTH-1:0]             o_q_wpc,
    output logic [$clog2(DATA_WIDTH/32)-1:0]  o_q_first_word,
    output logic                              o_q_flush,
    input  logic                              i_q_full
);

    localparam int LB = $clog2(DATA_WIDTH / 8);
    localparam int WS = $clog2(DATA_WIDTH / 32);
    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES  = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = LINE_BYTES - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] RESET_LINE  = RESET_PC & ~OFFSET_MASK;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_DRAIN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   line_addr;
    logic [WS-1:0]           first_word;
    logic [DATA_WIDTH-1:0]   line_buf;
    logic                    push;
    logic                    capture;
    logic                    unused_bits;

    // Byte-within-word bits of the redirect target carry no meaning here.
    assign unused_bits = ^i_redirect_pc[1:0];

    assign push    = (state == S_PUSH) && !i_q_full && !i_redirect;
    assign capture = (state == S_WAIT) && i_mem_rvalid && !i_redirect;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            line_addr  <= RESET_LINE;
            first_word <= RESET_PC[LB-1:2];
            line_buf   <= '0;
        end else begin
            if (i_redirect) begin
                line_addr  <= i_redirect_pc & ~OFFSET_MASK;
                first_word <= i_redirect_pc[LB-1:2];
            end else if (push) begin
                line_addr  <= line_addr + LINE_BYTES;
                first_word <= '0;
            end
            if (capture) begin
                line_buf <= i_mem_rdata;
            end
        end
    end

    // NOTE: next state defaults to the current state first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                // An ack in the redirect cycle leaves a stale response to swallow.
                if (i_redirect)     state_next = i_mem_ack ? S_DRAIN : S_REQ;
                else if (i_mem_ack) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_redirect)        state_next = i_mem_rvalid ? S_REQ : S_DRAIN;
                else if (i_mem_rvalid) state_next = S_PUSH;
            end
            S_PUSH: begin
                if (i_redirect || !i_q_full) state_next = S_REQ;
            end
            S_DRAIN: begin
                if (i_mem_rvalid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        o_mem_req      = !i_rst && (state == S_REQ);
        o_mem_addr     = i_rst ? RESET_LINE : line_addr;
        o_q_wen        = !i_rst && push;
        o_q_wdata      = i_rst ? '0 : line_buf;
        o_q_wpc        = line_addr;
        o_q_first_word = first_word;
        o_q_flush      = !i_rst && i_redirect;
    end

endmodule

// File: tb/tb_fetch_line_feeder.sv
// Bench for fetch_line_feeder: a memory model answers line requests and a
// scoreboard holds the lines expected in the fetch queue, in order.
`timescale 1ns/1ps

module tb_fetch_line_feeder;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int WS = 2;

    typedef struct {
        logic [AW-1:0] wpc;
        logic [DW-1:0] data;
        logic [WS-1:0] fw;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_redirect;
    logic [AW-1:0] i_redirect_pc;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ack;
    logic          i_mem_rvalid = 1'b0;
    logic [DW-1:0] i_mem_rdata  = '0;
    logic          o_q_wen;
    logic [DW-1:0] o_q_wdata;
    logic [AW-1:0] o_q_wpc;
    logic [WS-1:0] o_q_first_word;
    logic          o_q_flush;
    logic          i_q_full;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    int            rvalid_delay = 1;
    logic          poison       = 1'b0;
    int            pend_cnt     = 0;
    logic [DW-1:0] pend_data    = '0;
    logic          fire;
    logic [AW-1:0] fire_addr;

    fetch_line_feeder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC  (32'h0040_0000)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .o_q_wen       (o_q_wen),
        .o_q_wdata     (o_q_wdata),
        .o_q_wpc       (o_q_wpc),
        .o_q_first_word(o_q_first_word),
        .o_q_flush     (o_q_flush),
        .i_q_full      (i_q_full)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
        return {a ^ 32'h1357_9BDF, ~a, a + 32'h0101_0101, a};
    endfunction

    // Memory: accepts when ack is high during a request, answers rvalid_delay cycles later.
    always @(posedge i_clk) begin
        fire      = o_mem_req && i_mem_ack;
        fire_addr = o_mem_addr;
        #1;
        i_mem_rvalid = 1'b0;
        if (fire) begin
            pend_cnt  = rvalid_delay;
            pend_data = poison ? {4{32'hDEAD_BEEF}} : line_data(fire_addr);
        end
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = pend_data;
            end
        end
    end

    // Scoreboard: every queue write must match the oldest expected line.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_q_wen === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL push_unexpected got wpc=%h fw=%0d data=%h", o_q_wpc, o_q_first_word, o_q_wdata);
            end else begin
                e = sb.pop_front();
                if (o_q_wpc !== e.wpc || o_q_wdata !== e.data || o_q_first_word !== e.fw) begin
                    failures++;
                    $display("FAIL push got wpc=%h fw=%0d data=%h expected wpc=%h fw=%0d data=%h",
                             o_q_wpc, o_q_first_word, o_q_wdata, e.wpc, e.fw, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_line(input logic [AW-1:0] wpc, input logic [WS-1:0] fw);
        exp_t e;
        e.wpc  = wpc;
        e.data = line_data(wpc);
        e.fw   = fw;
        sb.push_back(e);
    endtask

    // Let the DUT run until all expected lines are pushed, then park it in S_REQ.
    task automatic drain(input string name);
        for (int c = 0; c < 200 && sb.size() != 0; c++) step();
        i_mem_ack = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got pending=%0d expected pending=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_5554;
        @(negedge i_clk);
        checks += 5;
        if (o_mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b expected=0", o_mem_req); end
        if (o_q_wen !== 1'b0) begin failures++; $display("FAIL rst_q_wen got=%b expected=0", o_q_wen); end
        if (o_q_flush !== 1'b0) begin failures++; $display("FAIL rst_q_flush got=%b expected=0", o_q_flush); end
        if (o_q_wdata !== '0) begin failures++; $display("FAIL rst_q_wdata got=%h expected=0", o_q_wdata); end
        if (o_mem_addr !== 32'h0040_0000) begin failures++; $display("FAIL rst_mem_addr got=%h expected=00400000", o_mem_addr); end
        step();
        i_redirect = 1'b0;
        i_rst      = 1'b0;
        @(negedge i_clk);
        checks += 2;
        if (o_mem_req !== 1'b1) begin failures++; $display("FAIL first_mem_req got=%b expected=1", o_mem_req); end
        if (o_mem_addr !== 32'h0040_0000) begin failures++; $display("FAIL first_mem_addr got=%h expected=00400000", o_mem_addr); end
    endtask

    task automatic test_sequential();
        expect_line(32'h0040_0000, 2'd0);
        expect_line(32'h0040_0010, 2'd0);
        expect_line(32'h0040_0020, 2'd0);
        i_mem_ack = 1'b1;
        drain("seq");
    endtask

    task automatic test_redirect_push();
        i_q_full  = 1'b1;
        i_mem_ack = 1'b1;
        repeat (3) step();
        expect_line(32'h0000_1230, 2'd2);
        expect_line(32'h0000_1240, 2'd0);
        i_q_full      = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_1238;
        @(negedge i_clk);
        checks += 2;
        if (o_q_flush !== 1'b1) begin failures++; $display("FAIL rdp_flush got=%b expected=1", o_q_flush); end
        if (o_q_wen !== 1'b0) begin failures++; $display("FAIL rdp_wen got=%b expected=0", o_q_wen); end
        step();
        i_redirect = 1'b0;
        @(negedge i_clk);
        checks += 2;
        if (o_mem_req !== 1'b1) begin failures++; $display("FAIL rdp_mem_req got=%b expected=1", o_mem_req); end
        if (o_mem_addr !== 32'h0000_1230) begin failures++; $display("FAIL rdp_mem_addr got=%h expected=00001230", o_mem_addr); end
        drain("rdp");
    endtask

    task automatic test_full_hold();
        i_q_full  = 1'b1;
        i_mem_ack = 1'b1;
        repeat (2) step();
        i_mem_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            checks += 3;
            if (o_q_wen !== 1'b0) begin failures++; $display("FAIL hold_wen cycle=%0d got=%b expected=0", c, o_q_wen); end
            if (o_mem_req !== 1'b0) begin failures++; $display("FAIL hold_mem_req cycle=%0d got=%b expected=0", c, o_mem_req); end
            if (o_q_wdata !== line_data(32'h0000_1250)) begin
                failures++;
                $display("FAIL hold_wdata cycle=%0d got=%h expected=%h", c, o_q_wdata, line_data(32'h0000_1250));
            end
            step();
        end
        expect_line(32'h0000_1250, 2'd0);
        i_q_full = 1'b0;
        step();
        @(negedge i_clk);
        checks += 3;
        if (sb.size() != 0) begin failures++; $display("FAIL hold_push got pending=%0d expected=0", sb.size()); sb.delete(); end
        if (o_mem_req !== 1'b1) begin failures++; $display("FAIL hold_next_req got=%b expected=1", o_mem_req); end
        if (o_mem_addr !== 32'h0000_1260) begin failures++; $display("FAIL hold_next_addr got=%h expected=00001260", o_mem_addr); end
    endtask

    task automatic test_stale_drain();
        logic seen;
        rvalid_delay = 3;
        poison       = 1'b1;
        i_mem_ack    = 1'b1;
        step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_2000;
        @(negedge i_clk);
        checks++;
        if (o_q_flush !== 1'b1) begin failures++; $display("FAIL stale_flush got=%b expected=1", o_q_flush); end
        step();
        i_redirect   = 1'b0;
        poison       = 1'b0;
        rvalid_delay = 1;
        expect_line(32'h0000_2000, 2'd0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge i_clk);
            if (i_mem_rvalid) seen = 1'b1;
            checks++;
            if (o_mem_req !== 1'b0) begin failures++; $display("FAIL stale_early_req cycle=%0d got=%b expected=0", c, o_mem_req); end
            step();
        end
        @(negedge i_clk);
        checks += 3;
        if (!seen) begin failures++; $display("FAIL stale_rvalid got=none expected=rvalid within 10 cycles"); end
        if (o_mem_req !== 1'b1) begin failures++; $display("FAIL stale_req got=%b expected=1", o_mem_req); end
        if (o_mem_addr !== 32'h0000_2000) begin failures++; $display("FAIL stale_addr got=%h expected=00002000", o_mem_addr); end
        drain("stale");
    endtask

    task automatic test_back_to_back();
        expect_line(32'hFFFF_FFF0, 2'd0);
        expect_line(32'h0000_0000, 2'd0);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_300C;
        @(negedge i_clk);
        checks++;
        if (o_q_flush !== 1'b1) begin failures++; $display("FAIL b2b_flush0 got=%b expected=1", o_q_flush); end
        step();
        i_redirect_pc = 32'hFFFF_FFF0;
        @(negedge i_clk);
        checks++;
        if (o_q_flush !== 1'b1) begin failures++; $display("FAIL b2b_flush1 got=%b expected=1", o_q_flush); end
        step();
        i_redirect = 1'b0;
        @(negedge i_clk);
        checks += 2;
        if (o_mem_req !== 1'b1) begin failures++; $display("FAIL b2b_req got=%b expected=1", o_mem_req); end
        if (o_mem_addr !== 32'hFFFF_FFF0) begin failures++; $display("FAIL b2b_addr got=%h expected=fffffff0", o_mem_addr); end
        i_mem_ack = 1'b1;
        drain("wrap");
    endtask

    task automatic test_rst_in_wait();
        rvalid_delay = 3;
        i_mem_ack    = 1'b1;
        step();
        i_rst     = 1'b1;
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        checks += 2;
        if (o_mem_req !== 1'b0) begin failures++; $display("FAIL rstw_mem_req got=%b expected=0", o_mem_req); end
        if (o_q_wen !== 1'b0) begin failures++; $display("FAIL rstw_wen got=%b expected=0", o_q_wen); end
        step();
        rvalid_delay = 1;
        step();
        i_rst = 1'b0;
        @(negedge i_clk);
        checks += 2;
        if (o_mem_req !== 1'b1) begin failures++; $display("FAIL rstw_req got=%b expected=1", o_mem_req); end
        if (o_mem_addr !== 32'h0040_0000) begin failures++; $display("FAIL rstw_addr got=%h expected=00400000", o_mem_addr); end
        step();
        @(negedge i_clk);
        checks += 2;
        if (o_mem_req !== 1'b1) begin failures++; $display("FAIL rstw_late_req got=%b expected=1", o_mem_req); end
        if (o_mem_addr !== 32'h0040_0000) begin failures++; $display("FAIL rstw_late_addr got=%h expected=00400000", o_mem_addr); end
        expect_line(32'h0040_0000, 2'd0);
        i_mem_ack = 1'b1;
        drain("rstw");
    endtask

    initial begin
        i_rst         = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_mem_ack     = 1'b0;
        i_q_full      = 1'b0;
        test_reset();
        test_sequential();
        test_redirect_push();
        test_full_hold();
        test_stale_drain();
        test_back_to_back();
        test_rst_in_wait();
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
